mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences the single byte-wide RAM port and shares it between two requesters: the instruction fetch unit, which reads whole 64-byte iCache blocks, and the load/store buffer, which issues 1/2/4-byte loads and stores. It sits between the core's memory clients and the external RAM bus. It owns the RAM address, write-enable and write-data lines. It returns a one-cycle `done` pulse with assembled data to the winning requester.

## Interface
- `BLK_BYTES`, 64, bytes per fetch block; fetch data width is `BLK_BYTES*8`.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `rdy` input 1: global enable; when 0, all state and outputs are frozen and `mem_wr` is forced to 0.
- `if_en` input 1: fetch request, held until `if_done`.
- `if_addr` input 32: block address; low 6 bits are 0.
- `if_done` output 1: one-cycle pulse when the block is ready.
- `if_data` output 512: block data; byte k is at [8k+7:8k].
- `ls_en` input 1: load/store request, held until `ls_done`.
- `ls_wr` input 1: 1 = store, 0 = load.
- `ls_addr` input 32: byte address.
- `ls_len` input 2: access length; 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
- `ls_wdata` input 32: store data, little-endian.
- `ls_done` output 1: one-cycle pulse on completion.
- `ls_rdata` output 32: load data, zero-extended; sign extension is done by the LSB.
- `flush` input 1: ROB misprediction clear.
- `mem_din` input 8: RAM read byte.
- `mem_dout` output 8: RAM write byte.
- `mem_a` output 32: RAM address.
- `mem_wr` output 1: 1 = write.

## Operation
- States:
  - IDLE
  - IF_RD: fetch read, `BLK_BYTES` bytes.
  - LS_RD: load, N bytes.
  - LS_WR: store, N bytes.
- N = 1, 2 or 4 from `ls_len`.
- IDLE arbitration:
  - If only one requester is pending, it wins.
  - If both are pending, the winner is chosen per Configuration.
- Read sequencing:
  - The address of byte i is driven in state cycle i.
  - `mem_din` carries byte i during cycle i+1.
  - A byte counter (7 bits) counts both addresses issued and bytes captured.
- Write sequencing:
  - Byte i of `ls_wdata` goes out on `mem_dout` with `mem_a = ls_addr+i` and `mem_wr = 1` in state cycle i.
  - The transfer is N cycles.
- Completion:
  - `done` is asserted for one cycle.
  - The state returns to IDLE on the same edge.
  - The requester drops `en` on that edge, so no re-grant occurs.
  - Data outputs hold until the next completion of the same requester.
- Flush:
  - If `flush = 1` while in IF_RD or LS_RD, the transfer aborts: go to IDLE, no `done`.
  - LS_WR is never aborted; a store in flight always completes and pulses `ls_done`.
  - `flush` in IDLE blocks the grant for that cycle only.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Simultaneous `flush` and final capture: flush wins for reads.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `mem_a`, `mem_dout` = 0; `mem_wr` = 0.
  - `if_done`, `ls_done` = 0.
  - `if_data`, `ls_rdata` = 0.
  - Round-robin pointer = fetch.
- Grant: `en` is sampled in IDLE at edge 0; the first address is driven in the cycle after edge 0.
- Latency from grant edge to `done` pulse:
  - Read: N+1 cycles (load) or 65 cycles (fetch).
  - Write: N cycles.
- One idle cycle minimum between transfers.
- `mem_wr` is 0 in every non-LS_WR cycle and in every cycle with `rdy = 0`.

## Configuration
- `MEMC_RR_EN` defined:
  - Round-robin on contention.
  - The pointer flips to the other requester after each granted transfer.
- `MEMC_RR_EN` undefined:
  - Fixed priority; LSB always wins on contention.
  - The pointer logic is removed.

## Test plan
- Fetch only, `if_addr = 0x40`, RAM bytes = address[7:0]:
  - `if_done` arrives 65 cycles after grant.
  - `if_data` byte k = 0x40+k.
- Store `ls_len = 2`, `ls_addr = 0x1000`, `ls_wdata = 0xDEADBEEF`:
  - Writes EF, BE, AD, DE to 0x1000–0x1003.
  - `mem_wr` is high exactly 4 cycles.
  - `ls_done` arrives 4 cycles after grant.
- Byte load at 0x1003 after the store above:
  - `ls_rdata = 0x000000DE`.
  - `ls_done` arrives 2 cycles after grant.
- `if_en` and `ls_en` rise in the same cycle, repeated twice:
  - With `MEMC_RR_EN`: grants go fetch, LSB, fetch, LSB.
  - Without it: LSB, fetch, LSB, fetch (each requester re-asserts).
- `flush` at cycle 10 of a fetch: no `if_done`, state back in IDLE, next request granted normally.
- `flush` during a 4-byte store: all 4 bytes are written and `ls_done` pulses.
- `rdy = 0` for 3 cycles mid-load:
  - Completion is delayed by exactly 3 cycles.
  - `mem_wr` stays 0.
- `rst = 0` mid-store: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the byte-wide RAM port for iCache block fetches and LSB loads/stores.
// Optional MEMC_RR_EN: round-robin arbitration on contention (default: LSB has fixed priority).
module mem_arbiter #(
    parameter int BLK_BYTES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   if_en,
    input  logic [31:0]            if_addr,
    output logic                   if_done,
    output logic [BLK_BYTES*8-1:0] if_data,
    input  logic                   ls_en,
    input  logic                   ls_wr,
    input  logic [31:0]            ls_addr,
    input  logic [1:0]             ls_len,
    input  logic [31:0]            ls_wdata,
    output logic                   ls_done,
    output logic [31:0]            ls_rdata,
    input  logic                   flush,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [31:0]            mem_a,
    output logic                   mem_wr
);
    localparam int CNT_W = $clog2(BLK_BYTES + 1);
    localparam int BLK_W = BLK_BYTES * 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IF_RD = 2'd1;
    localparam logic [1:0] ST_LS_RD = 2'd2;
    localparam logic [1:0] ST_LS_WR = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ls_n;
    logic [31:0]      r_base;
    logic [31:0]      r_wdata;
    logic [31:0]      r_mem_a;
    logic [7:0]       r_mem_dout;
    logic             r_mem_wr;
    logic             r_if_done;
    logic             r_ls_done;
    logic [BLK_W-1:0] r_if_buf;
    logic [BLK_W-1:0] r_if_data;
    logic [31:0]      r_ls_buf;
    logic [31:0]      r_ls_rdata;
`ifdef MEMC_RR_EN
    logic             r_rr_ptr;   // 0 = fetch wins next contention, 1 = LSB
`endif

    logic             w_block;
    logic             w_grant_if;
    logic             w_grant_ls;
    logic             w_more;
    logic             w_last;
    logic [CNT_W-1:0] w_ls_n;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [4:0]       w_ls_sh;
    logic [31:0]      w_addr_nxt;
    logic [31:0]      w_ls_shift;
    logic [BLK_W-1:0] w_if_shift;

    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_rdata = r_ls_rdata;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign mem_wr   = r_mem_wr & rdy;

    always_comb begin
        w_ls_n = CNT_W'(4);
        case (ls_len)
            2'd0:    w_ls_n = CNT_W'(1);
            2'd1:    w_ls_n = CNT_W'(2);
            default: w_ls_n = CNT_W'(4);
        endcase
    end

    // Loaded bytes enter at the top; shift the N valid bytes down to bit 0.
    always_comb begin
        w_ls_sh = 5'd0;
        case (r_ls_n)
            CNT_W'(1): w_ls_sh = 5'd24;
            CNT_W'(2): w_ls_sh = 5'd16;
            default:   w_ls_sh = 5'd0;
        endcase
    end

    assign w_n        = (r_state == ST_IF_RD) ? CNT_W'(BLK_BYTES) : r_ls_n;
    assign w_cnt_nxt  = r_cnt + 1'b1;
    assign w_more     = (w_cnt_nxt < w_n);
    assign w_last     = (r_cnt == w_n);
    assign w_addr_nxt = r_base + 32'(w_cnt_nxt);
    assign w_if_shift = {mem_din, r_if_buf[BLK_W-1:8]};
    assign w_ls_shift = {mem_din, r_ls_buf[31:8]};

    // A done pulse still high means the requester has not yet dropped en.
    assign w_block = flush | r_if_done | r_ls_done;

    always_comb begin
        w_grant_if = 1'b0;
        w_grant_ls = 1'b0;
        if (r_state == ST_IDLE && !w_block) begin
            if (if_en && ls_en) begin
`ifdef MEMC_RR_EN
                w_grant_if = ~r_rr_ptr;
                w_grant_ls = r_rr_ptr;
`else
                w_grant_ls = 1'b1;
`endif
            end else begin
                w_grant_if = if_en;
                w_grant_ls = ls_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ls_n     <= '0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_buf   <= '0;
            r_if_data  <= '0;
            r_ls_buf   <= '0;
            r_ls_rdata <= '0;
`ifdef MEMC_RR_EN
            r_rr_ptr   <= 1'b0;
`endif
        end else if (rdy) begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
`ifdef MEMC_RR_EN
                    if (w_grant_if || w_grant_ls)
                        r_rr_ptr <= w_grant_if;
`endif
                    if (w_grant_if) begin
                        r_state <= ST_IF_RD;
                        r_base  <= if_addr;
                        r_mem_a <= if_addr;
                    end else if (w_grant_ls) begin
                        r_base  <= ls_addr;
                        r_mem_a <= ls_addr;
                        r_ls_n  <= w_ls_n;
                        if (ls_wr) begin
                            r_state    <= ST_LS_WR;
                            r_mem_dout <= ls_wdata[7:0];
                            r_wdata    <= ls_wdata >> 8;
                            r_mem_wr   <= 1'b1;
                        end else begin
                            r_state <= ST_LS_RD;
                        end
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    // Flush beats the final capture: no done, data outputs untouched.
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_more)
                            r_mem_a <= w_addr_nxt;
                        if (r_cnt != '0) begin
                            if (r_state == ST_IF_RD) r_if_buf <= w_if_shift;
                            else                     r_ls_buf <= w_ls_shift;
                        end
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            if (r_state == ST_IF_RD) begin
                                r_if_data <= w_if_shift;
                                r_if_done <= 1'b1;
                            end else begin
                                r_ls_rdata <= w_ls_shift >> w_ls_sh;
                                r_ls_done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_LS_WR: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_more) begin
                        r_mem_a    <= w_addr_nxt;
                        r_mem_dout <= r_wdata[7:0];
                        r_wdata    <= r_wdata >> 8;
                    end else begin
                        r_mem_wr  <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_ls_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, data, arbitration order, flush, rdy stall, async reset.
module tb_mem_arbiter;
    localparam int BLK = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rdy = 1'b1;
    logic             if_en = 1'b0;
    logic [31:0]      if_addr = '0;
    logic             if_done;
    logic [BLK*8-1:0] if_data;
    logic             ls_en = 1'b0;
    logic             ls_wr = 1'b0;
    logic [31:0]      ls_addr = '0;
    logic [1:0]       ls_len = '0;
    logic [31:0]      ls_wdata = '0;
    logic             ls_done;
    logic [31:0]      ls_rdata;
    logic             flush = 1'b0;
    logic [7:0]       mem_din = '0;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;

    logic [7:0] ram [0:65535];
    int cyc = 0;
    int wr_cnt = 0;
    int if_done_cnt = 0;
    int n_chk = 0;
    int n_err = 0;
    int order[$];

    mem_arbiter #(.BLK_BYTES(BLK)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_en(ls_en), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, frozen together with the rest of the system by rdy.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
        if (rdy) mem_din <= ram[mem_a[15:0]];
        if (if_done) if_done_cnt <= if_done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] blk(input logic [7:0] b);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < BLK; k++) v[8*k +: 8] = b + 8'(k);
        return v;
    endfunction

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    endfunction

    task automatic if_req(input logic [31:0] a, output int c0);
        if_addr = a; if_en = 1'b1; c0 = cyc;
    endtask

    task automatic ls_req(input logic wr, input logic [31:0] a, input logic [1:0] len,
                          input logic [31:0] wd, output int c0);
        ls_wr = wr; ls_addr = a; ls_len = len; ls_wdata = wd; ls_en = 1'b1; c0 = cyc;
    endtask

    // Returns cycles from grant edge to the done pulse, -1 on timeout.
    task automatic wait_done(input bit want_if, input int c0, output int lat);
        lat = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (want_if ? if_done : ls_done) begin
                lat = cyc - c0 - 1;
                break;
            end
        end
        if (want_if) if_en = 1'b0; else ls_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0, lat, w0, d0;
        int exp_ord[4];
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i);

        idle(2);
        chk("rst_if_done",  512'(if_done), '0);
        chk("rst_ls_done",  512'(ls_done), '0);
        chk("rst_mem_wr",   512'(mem_wr), '0);
        chk("rst_mem_a",    512'(mem_a), '0);
        chk("rst_mem_dout", 512'(mem_dout), '0);
        chk("rst_if_data",  512'(if_data), '0);
        chk("rst_ls_rdata", 512'(ls_rdata), '0);
        rst = 1'b1;
        idle(2);

        if_req(32'h40, c0);
        wait_done(1'b1, c0, lat);
        chk("fetch_lat",  512'(lat), 512'(65));
        chk("fetch_data", if_data, blk(8'h40));
        idle(2);

        w0 = wr_cnt;
        ls_req(1'b1, 32'h1000, 2'd2, 32'hDEADBEEF, c0);
        wait_done(1'b0, c0, lat);
        chk("st_lat",  512'(lat), 512'(4));
        chk("st_wrs",  512'(wr_cnt - w0), 512'(4));
        chk("st_ram",  512'(ram_word(32'h1000)), 512'(32'hDEADBEEF));
        idle(2);

        ls_req(1'b0, 32'h1003, 2'd0, '0, c0);
        wait_done(1'b0, c0, lat);
        chk("ld1_lat",  512'(lat), 512'(2));
        chk("ld1_data", 512'(ls_rdata), 512'(32'h000000DE));
        chk("if_hold",  if_data, blk(8'h40));
        idle(2);

        ls_req(1'b0, 32'h1001, 2'd1, '0, c0);
        wait_done(1'b0, c0, lat);
        chk("ld2_lat",  512'(lat), 512'(3));
        chk("ld2_data", 512'(ls_rdata), 512'(32'h0000ADBE));
        idle(2);

        ls_req(1'b0, 32'h1000, 2'd2, '0, c0);
        wait_done(1'b0, c0, lat);
        chk("ld4_lat",  512'(lat), 512'(5));
        chk("ld4_data", 512'(ls_rdata), 512'(32'hDEADBEEF));
        idle(2);

        // Contention: both requesters rise together, twice.
        for (int r = 0; r < 2; r++) begin
            ls_wr = 1'b0; ls_addr = 32'h1000; ls_len = 2'd2;
            if_addr = 32'h80;
            if_en = 1'b1; ls_en = 1'b1;
            for (int n = 0; n < 400 && (if_en || ls_en); n++) begin
                @(negedge clk);
                if (if_done) begin order.push_back(0); if_en = 1'b0; end
                if (ls_done) begin order.push_back(1); ls_en = 1'b0; end
            end
            if_en = 1'b0; ls_en = 1'b0;
            idle(2);
        end
`ifdef MEMC_RR_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{1, 0, 1, 0};
`endif
        chk("arb_cnt", 512'(order.size()), 512'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("arb_ord%0d", i), 512'(i < order.size() ? order[i] : -1), 512'(exp_ord[i]));
        chk("arb_if_data", if_data, blk(8'h80));
        chk("arb_ls_data", 512'(ls_rdata), 512'(32'hDEADBEEF));

        // Flush in cycle 10 of a fetch.
        d0 = if_done_cnt;
        if_req(32'hC0, c0);
        idle(10);
        flush = 1'b1; if_en = 1'b0;
        idle(1);
        flush = 1'b0;
        idle(80);
        chk("fl_no_done", 512'(if_done_cnt - d0), '0);
        chk("fl_if_hold", if_data, blk(8'h80));
        if_req(32'h100, c0);
        wait_done(1'b1, c0, lat);
        chk("fl_next_lat",  512'(lat), 512'(65));
        chk("fl_next_data", if_data, blk(8'h00));
        idle(2);

        // Flush during a store must not abort it.
        w0 = wr_cnt;
        ls_req(1'b1, 32'h2000, 2'd2, 32'h12345678, c0);
        idle(2);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        wait_done(1'b0, c0, lat);
        chk("flst_lat", 512'(lat), 512'(4));
        chk("flst_wrs", 512'(wr_cnt - w0), 512'(4));
        chk("flst_ram", 512'(ram_word(32'h2000)), 512'(32'h12345678));
        idle(2);

        // rdy low for 3 cycles mid-load.
        w0 = wr_cnt;
        ls_req(1'b0, 32'h2000, 2'd2, '0, c0);
        idle(2);
        rdy = 1'b0;
        idle(3);
        rdy = 1'b1;
        wait_done(1'b0, c0, lat);
        chk("rdyld_lat",  512'(lat), 512'(8));
        chk("rdyld_data", 512'(ls_rdata), 512'(32'h12345678));
        chk("rdyld_wrs",  512'(wr_cnt - w0), '0);
        idle(2);

        // rdy low for 3 cycles mid-store: mem_wr forced low while stalled.
        w0 = wr_cnt;
        ls_req(1'b1, 32'h3000, 2'd2, 32'hA1B2C3D4, c0);
        idle(2);
        rdy = 1'b0;
        idle(1);
        chk("rdyst_wr_low", 512'(mem_wr), '0);
        idle(2);
        rdy = 1'b1;
        wait_done(1'b0, c0, lat);
        chk("rdyst_lat", 512'(lat), 512'(7));
        chk("rdyst_wrs", 512'(wr_cnt - w0), 512'(4));
        chk("rdyst_ram", 512'(ram_word(32'h3000)), 512'(32'hA1B2C3D4));
        idle(2);

        // Asynchronous reset in the middle of a store.
        ls_req(1'b1, 32'h4000, 2'd2, 32'h55AA66BB, c0);
        idle(2);
        chk("mid_wr_on", 512'(mem_wr), 512'(1));
        #2 rst = 1'b0;
        #1;
        chk("ar_mem_wr",   512'(mem_wr), '0);
        chk("ar_mem_a",    512'(mem_a), '0);
        chk("ar_mem_dout", 512'(mem_dout), '0);
        chk("ar_ls_done",  512'(ls_done), '0);
        chk("ar_if_data",  512'(if_data), '0);
        chk("ar_ls_rdata", 512'(ls_rdata), '0);
        ls_en = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
